// File: rtl/srpt_grant_rx.sv
// Sender-side Homa GRANT consumer: tracks the highest granted offset per outbound RPC
// and emits one send-update record to the SRPT send queue for every grant that advances it.
module srpt_grant_rx #(
  parameter int TABLE_BITS = 6,
  parameter int CNT_W      = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             grant_pkt_empty_i,
  output logic             grant_pkt_read_en_o,
  input  logic [94:0]      grant_pkt_data_i,
  input  logic             send_upd_full_i,
  output logic             send_upd_write_en_o,
  output logic [94:0]      send_upd_data_o,
  input  logic             rpc_clear_i,
  input  logic [13:0]      rpc_clear_id_i,
  output logic [CNT_W-1:0] stale_cnt_o,
  output logic [CNT_W-1:0] clamp_cnt_o
);

  localparam int DEPTH = 1 << TABLE_BITS;

  typedef enum logic [1:0] {IDLE, LOOK, CMP, EMIT} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [31:0] clamp_off(input logic [31:0] off, input logic [31:0] len);
    return (off > len) ? len : off;
  endfunction

  state_t state, state_nxt;

  logic [DEPTH-1:0] valid;
  logic [13:0]      tag_ram [DEPTH];
  logic [31:0]      off_ram [DEPTH];

  logic [94:0]      pkt_p0;
  logic [13:0]      tag_rd_p0;
  logic [31:0]      off_rd_p0;
  logic             clr_vld_p0;
  logic [13:0]      clr_id_p0;
  logic [13:0]      clr_tag_p0;
  logic [94:0]      upd_data_p1;
  logic [CNT_W-1:0] stale_cnt;
  logic [CNT_W-1:0] clamp_cnt;

  logic                  pop;
  logic [TABLE_BITS-1:0] in_idx;
  logic [TABLE_BITS-1:0] clr_in_idx;
  logic [TABLE_BITS-1:0] clr_idx_p0;
  logic [TABLE_BITS-1:0] cmp_idx;
  logic [2:0]            prio_p0;
  logic [13:0]           rpc_id_p0;
  logic [13:0]           peer_id_p0;
  logic [31:0]           grant_off_p0;
  logic [31:0]           msg_len_p0;
  logic [31:0]           eff_off;
  logic [31:0]           prev_off;
  logic                  hit;
  logic                  advance;
  logic                  wr_en;
  logic                  clr_hit;

  assign pop        = ap_rst_n && (state == IDLE) && !grant_pkt_empty_i;
  assign in_idx     = grant_pkt_data_i[78 +: TABLE_BITS];
  assign clr_in_idx = rpc_clear_id_i[TABLE_BITS-1:0];
  assign clr_idx_p0 = clr_id_p0[TABLE_BITS-1:0];

  assign prio_p0      = pkt_p0[94:92];
  assign rpc_id_p0    = pkt_p0[91:78];
  assign peer_id_p0   = pkt_p0[77:64];
  assign grant_off_p0 = pkt_p0[63:32];
  assign msg_len_p0   = pkt_p0[31:0];
  assign cmp_idx      = rpc_id_p0[TABLE_BITS-1:0];

  // Compare stage: a valid entry with a different tag is an alias and counts as no history.
  assign eff_off  = clamp_off(grant_off_p0, msg_len_p0);
  assign hit      = valid[cmp_idx] && (tag_rd_p0 == rpc_id_p0);
  assign prev_off = hit ? off_rd_p0 : 32'd0;
  assign advance  = eff_off > prev_off;
  assign wr_en    = (state == CMP) && advance;
  assign clr_hit  = clr_vld_p0 && valid[clr_idx_p0] && (clr_tag_p0 == clr_id_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!grant_pkt_empty_i) state_nxt = LOOK;
      LOOK: state_nxt = CMP;
      CMP:  state_nxt = advance ? EMIT : IDLE;
      EMIT: if (!send_upd_full_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_pkt_read_en_o = pop;
  assign send_upd_write_en_o = (state == EMIT) && !send_upd_full_i;
  assign send_upd_data_o     = upd_data_p1;
  assign stale_cnt_o         = stale_cnt;
  assign clamp_cnt_o         = clamp_cnt;

  // Control state: the CMP write is ordered after the clear so it wins on the same index.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      clr_vld_p0  <= 1'b0;
      stale_cnt   <= '0;
      clamp_cnt   <= '0;
      upd_data_p1 <= '0;
    end else begin
      state      <= state_nxt;
      clr_vld_p0 <= rpc_clear_i;
      if (clr_hit) valid[clr_idx_p0] <= 1'b0;
      if (wr_en)   valid[cmp_idx]    <= 1'b1;
      if (state == CMP) begin
        if (grant_off_p0 > msg_len_p0) clamp_cnt <= sat_inc(clamp_cnt);
        if (advance)
          upd_data_p1 <= {prio_p0, rpc_id_p0, peer_id_p0, eff_off, eff_off - prev_off};
        else
          stale_cnt <= sat_inc(stale_cnt);
      end
    end
  end

  // Pop/lookup stage: packet latch and synchronous table reads; a same-cycle write is forwarded to the clear tag.
  always_ff @(posedge ap_clk) begin
    if (pop) begin
      pkt_p0    <= grant_pkt_data_i;
      tag_rd_p0 <= tag_ram[in_idx];
      off_rd_p0 <= off_ram[in_idx];
    end
    if (rpc_clear_i) begin
      clr_id_p0  <= rpc_clear_id_i;
      clr_tag_p0 <= (wr_en && (cmp_idx == clr_in_idx)) ? rpc_id_p0 : tag_ram[clr_in_idx];
    end
    if (wr_en) begin
      tag_ram[cmp_idx] <= rpc_id_p0;
      off_ram[cmp_idx] <= eff_off;
    end
  end

endmodule

// File: tb/tb_srpt_grant_rx.sv
// Bench for srpt_grant_rx: hand vector table, multi-cycle corner sequences, and random
// grants checked against a per-index table model of the grant rules.
module tb_srpt_grant_rx;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        grant_pkt_empty_i;
  logic        grant_pkt_read_en_o;
  logic [94:0] grant_pkt_data_i;
  logic        send_upd_full_i;
  logic        send_upd_write_en_o;
  logic [94:0] send_upd_data_o;
  logic        rpc_clear_i;
  logic [13:0] rpc_clear_id_i;
  logic [15:0] stale_cnt_o;
  logic [15:0] clamp_cnt_o;

  srpt_grant_rx #(.TABLE_BITS(6), .CNT_W(16)) dut (
    .ap_clk              (ap_clk),
    .ap_rst_n            (ap_rst_n),
    .grant_pkt_empty_i   (grant_pkt_empty_i),
    .grant_pkt_read_en_o (grant_pkt_read_en_o),
    .grant_pkt_data_i    (grant_pkt_data_i),
    .send_upd_full_i     (send_upd_full_i),
    .send_upd_write_en_o (send_upd_write_en_o),
    .send_upd_data_o     (send_upd_data_o),
    .rpc_clear_i         (rpc_clear_i),
    .rpc_clear_id_i      (rpc_clear_id_i),
    .stale_cnt_o         (stale_cnt_o),
    .clamp_cnt_o         (clamp_cnt_o)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pop = 0;
  int last_push = 0;

  logic [94:0] in_q[$];
  logic [94:0] exp_q[$];
  logic [94:0] got_q[$];

  // Reference model: one slot per index, holding the last RPC that advanced there.
  bit          m_v[64];
  logic [13:0] m_tag[64];
  logic [31:0] m_off[64];
  int          m_stale = 0;
  int          m_clamp = 0;

  task automatic chk(input bit ok, input string nm, input logic [94:0] act, input logic [94:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic model_grant(input logic [94:0] p);
    logic [13:0] rpc;
    logic [31:0] off, len, eff, prev;
    int idx;
    rpc = p[91:78];
    off = p[63:32];
    len = p[31:0];
    idx = int'(rpc) % 64;
    eff = (off > len) ? len : off;
    if (off > len) m_clamp++;
    prev = (m_v[idx] && m_tag[idx] == rpc) ? m_off[idx] : 32'd0;
    if (eff > prev) begin
      m_v[idx] = 1'b1;
      m_tag[idx] = rpc;
      m_off[idx] = eff;
      exp_q.push_back({p[94:64], eff, eff - prev});
    end else begin
      m_stale++;
    end
  endtask

  task automatic model_clear(input logic [13:0] id);
    int idx;
    idx = int'(id) % 64;
    if (m_v[idx] && m_tag[idx] == id) m_v[idx] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
    m_stale = 0;
    m_clamp = 0;
    exp_q.delete();
  endtask

  // FWFT source, sink recorder and per-cycle protocol checks.
  initial begin : mon
    logic re, we, fl;
    logic [94:0] d, e, p;
    grant_pkt_empty_i = 1'b1;
    grant_pkt_data_i  = '0;
    forever begin
      @(negedge ap_clk);
      re = grant_pkt_read_en_o;
      we = send_upd_write_en_o;
      fl = send_upd_full_i;
      d  = send_upd_data_o;
      if (ap_rst_n) begin
        chk(!(we && fl), "write_while_full", 95'(we), 95'(0));
        if (re) chk(exp_q.size() == 0, "pop_while_pending", 95'(exp_q.size()), 95'(0));
        if (re) chk(in_q.size() != 0, "pop_while_empty", 95'(in_q.size()), 95'(1));
      end
      @(posedge ap_clk);
      #1;
      cyc++;
      if (re && in_q.size() != 0) begin
        p = in_q.pop_front();
        model_grant(p);
        last_pop = cyc;
      end
      if (we) begin
        got_q.push_back(d);
        last_push = cyc;
        if (exp_q.size() == 0) chk(1'b0, "unexpected_push", d, 95'(0));
        else begin
          e = exp_q.pop_front();
          chk(d == e, "push_vs_model", d, e);
        end
      end
      grant_pkt_empty_i = (in_q.size() == 0);
      grant_pkt_data_i  = (in_q.size() == 0) ? 95'(0) : in_q[0];
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic send_grant(input logic [2:0] pr, input logic [13:0] rpc, input logic [13:0] peer,
                            input logic [31:0] off, input logic [31:0] len);
    in_q.push_back({pr, rpc, peer, off, len});
  endtask

  task automatic wait_idle(input bit rnd_full);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
      @(posedge ap_clk);
      #2;
      if (rnd_full) send_upd_full_i = ($urandom_range(0, 2) == 0);
      n++;
    end
    send_upd_full_i = 1'b0;
    repeat (5) @(posedge ap_clk);
    #2;
    chk(n < 400, "idle_timeout", 95'(n), 95'(400));
  endtask

  task automatic do_clear(input logic [13:0] id);
    @(posedge ap_clk);
    #2;
    rpc_clear_i = 1'b1;
    rpc_clear_id_i = id;
    model_clear(id);
    @(posedge ap_clk);
    #2;
    rpc_clear_i = 1'b0;
    repeat (3) @(posedge ap_clk);
    #2;
  endtask

  typedef struct {
    logic [2:0]  prio;
    logic [13:0] rpc;
    logic [13:0] peer;
    logic [31:0] off;
    logic [31:0] len;
    int          npush;
    logic [31:0] new_off;
    logic [31:0] delta;
  } vec_t;

  vec_t vt[6];

  initial begin : main
    logic [94:0] d0, req;
    bit stable, nopop;

    vt[0] = '{3'd2, 14'd5,  14'd9, 32'h1000, 32'h4000, 1, 32'h1000, 32'h1000};
    vt[1] = '{3'd2, 14'd5,  14'd9, 32'h1000, 32'h4000, 0, 32'h0,    32'h0};
    vt[2] = '{3'd2, 14'd5,  14'd9, 32'h0800, 32'h4000, 0, 32'h0,    32'h0};
    vt[3] = '{3'd2, 14'd5,  14'd9, 32'h3000, 32'h4000, 1, 32'h3000, 32'h2000};
    vt[4] = '{3'd2, 14'd5,  14'd9, 32'h5000, 32'h4000, 1, 32'h4000, 32'h1000};
    vt[5] = '{3'd1, 14'd69, 14'd3, 32'h0100, 32'h4000, 1, 32'h0100, 32'h0100};

    ap_rst_n = 1'b0;
    send_upd_full_i = 1'b0;
    rpc_clear_i = 1'b0;
    rpc_clear_id_i = '0;
    model_reset();
    repeat (3) @(posedge ap_clk);
    #2;
    chk(grant_pkt_read_en_o == 1'b0, "rst_read_en", 95'(grant_pkt_read_en_o), 95'(0));
    chk(send_upd_write_en_o == 1'b0, "rst_write_en", 95'(send_upd_write_en_o), 95'(0));
    chk(send_upd_data_o == '0, "rst_data", send_upd_data_o, 95'(0));
    chk(stale_cnt_o == 16'd0, "rst_stale", 95'(stale_cnt_o), 95'(0));
    chk(clamp_cnt_o == 16'd0, "rst_clamp", 95'(clamp_cnt_o), 95'(0));
    ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);
    #2;

    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      send_grant(vt[i].prio, vt[i].rpc, vt[i].peer, vt[i].off, vt[i].len);
      wait_idle(1'b0);
      chk(got_q.size() == vt[i].npush, "vec_push_count", 95'(got_q.size()), 95'(vt[i].npush));
      if (vt[i].npush == 1 && got_q.size() == 1) begin
        req = {vt[i].prio, vt[i].rpc, vt[i].peer, vt[i].new_off, vt[i].delta};
        chk(got_q[0] == req, "vec_push_data", got_q[0], req);
      end
      if (i == 0) chk(last_push - last_pop == 3, "first_latency", 95'(last_push - last_pop), 95'(3));
      if (i == 4) begin
        chk(stale_cnt_o == 16'd2, "stale_after_dups", 95'(stale_cnt_o), 95'(2));
        chk(clamp_cnt_o == 16'd1, "clamp_after_over", 95'(clamp_cnt_o), 95'(1));
      end
    end

    // Clear of the resident RPC empties the slot; a clear with a foreign tag is ignored.
    do_clear(14'd69);
    got_q.delete();
    send_grant(3'd1, 14'd69, 14'd3, 32'h100, 32'h4000);
    wait_idle(1'b0);
    req = {3'd1, 14'd69, 14'd3, 32'h100, 32'h100};
    chk(got_q.size() == 1 && got_q[0] == req, "regrant_after_clear", got_q.size() ? got_q[0] : 95'(0), req);
    do_clear(14'd133);
    got_q.delete();
    send_grant(3'd1, 14'd69, 14'd3, 32'h180, 32'h4000);
    wait_idle(1'b0);
    req = {3'd1, 14'd69, 14'd3, 32'h180, 32'h80};
    chk(got_q.size() == 1 && got_q[0] == req, "foreign_clear_ignored", got_q.size() ? got_q[0] : 95'(0), req);

    // Back-pressure: output held, no pop of the queued grant behind it.
    got_q.delete();
    send_upd_full_i = 1'b1;
    send_grant(3'd4, 14'd7, 14'd11, 32'h10, 32'h100);
    send_grant(3'd5, 14'd8, 14'd12, 32'h20, 32'h100);
    repeat (6) @(posedge ap_clk);
    @(negedge ap_clk);
    d0 = send_upd_data_o;
    stable = 1'b1;
    nopop = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      if (send_upd_data_o != d0) stable = 1'b0;
      if (grant_pkt_read_en_o || in_q.size() != 1) nopop = 1'b0;
    end
    req = {3'd4, 14'd7, 14'd11, 32'h10, 32'h10};
    chk(d0 == req, "held_data", d0, req);
    chk(stable, "held_stable", 95'(stable), 95'(1));
    chk(nopop, "no_pop_while_full", 95'(nopop), 95'(1));
    chk(got_q.size() == 0, "no_push_while_full", 95'(got_q.size()), 95'(0));
    @(posedge ap_clk);
    #2;
    send_upd_full_i = 1'b0;
    wait_idle(1'b0);
    req = {3'd5, 14'd8, 14'd12, 32'h20, 32'h20};
    chk(got_q.size() == 2, "pushes_after_release", 95'(got_q.size()), 95'(2));
    if (got_q.size() == 2) chk(got_q[1] == req, "second_after_release", got_q[1], req);

    // Reset during EMIT drops the record, the counters and the whole table.
    got_q.delete();
    send_upd_full_i = 1'b1;
    send_grant(3'd0, 14'd10, 14'd1, 32'h40, 32'h100);
    repeat (6) @(posedge ap_clk);
    #3;
    send_upd_full_i = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    chk(send_upd_write_en_o == 1'b0, "write_en_in_reset", 95'(send_upd_write_en_o), 95'(0));
    model_reset();
    got_q.delete();
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #2;
    chk(stale_cnt_o == 16'd0, "stale_after_reset", 95'(stale_cnt_o), 95'(0));
    chk(clamp_cnt_o == 16'd0, "clamp_after_reset", 95'(clamp_cnt_o), 95'(0));
    send_grant(3'd2, 14'd5, 14'd9, 32'h1000, 32'h4000);
    wait_idle(1'b0);
    req = {3'd2, 14'd5, 14'd9, 32'h1000, 32'h1000};
    chk(got_q.size() == 1 && got_q[0] == req, "table_empty_after_reset", got_q.size() ? got_q[0] : 95'(0), req);

    // Random grants with aliasing ids, random back-pressure and occasional clears.
    for (int b = 0; b < 80; b++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        send_grant(3'($urandom_range(0, 7)),
                   14'($urandom_range(0, 2) * 64 + $urandom_range(0, 3)),
                   14'($urandom_range(0, 16383)),
                   32'($urandom_range(0, 32'h3000)),
                   32'($urandom_range(32'h800, 32'h2800)));
      end
      wait_idle(1'b1);
      if ($urandom_range(0, 3) == 0) do_clear(14'($urandom_range(0, 2) * 64 + $urandom_range(0, 3)));
    end
    chk(stale_cnt_o == 16'(m_stale), "random_stale_cnt", 95'(stale_cnt_o), 95'(m_stale));
    chk(clamp_cnt_o == 16'(m_clamp), "random_clamp_cnt", 95'(clamp_cnt_o), 95'(m_clamp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
